// File: rtl/lc3_pipeline_ctrl.sv
// LC-3 five-stage pipeline controller: startup sequencing, memory-access FSM, stall and forwarding control.
// Optional macro LC3_CTRL_BYPASS_EN enables operand forwarding; without it, RAW hazards cost a one-cycle stall.
module lc3_pipeline_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [15:0] IMem_dout,
    input  logic [2:0]  NZP,
    input  logic [2:0]  psr,
    output logic        enable_updatePC,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        br_taken,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic        bypass_mem_1,
    output logic [1:0]  mem_state
);

    typedef enum logic [1:0] {
        MEM_READ     = 2'd0,
        MEM_WRITE    = 2'd1,
        MEM_INDIRECT = 2'd2,
        MEM_IDLE     = 2'd3
    } memState_e;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;

    memState_e   state_q, state_d;
    logic        memServed_q, memServed_d;
    logic        loadDone_q, loadDone_d;
    logic [1:0]  startCnt_q, startCnt_d;

    logic [3:0]  opExec, opDec;
    logic        execIsLoad, execIsAlu, execIsAlu2;
    logic        ctrlExec, ctrlDec, branchTaken;
    logic        fwdAlu1, fwdAlu2, fwdMem1, dataStall;

    // The fetched word and the offset/immediate fields never influence control.
    logic        unusedBits;
    assign unusedBits = ^{IMem_dout, IR[4:3], IR_Exec[8:0]};

    assign opExec = IR_Exec[15:12];
    assign opDec  = IR[15:12];

    assign execIsLoad = (opExec == OP_LD) || (opExec == OP_LDR) || (opExec == OP_LDI);
    assign execIsAlu2 = (opExec == OP_ADD) || (opExec == OP_AND);
    assign execIsAlu  = execIsAlu2 || (opExec == OP_NOT);

    // A BR with an empty condition field is the LC-3 NOP and never redirects the PC.
    assign ctrlExec = ((opExec == OP_BR) && (IR_Exec[11:9] != 3'b000)) || (opExec == OP_JMP);
    assign ctrlDec  = ((opDec == OP_BR) && (IR[11:9] != 3'b000)) || (opDec == OP_JMP);
    assign branchTaken = (opExec == OP_JMP) || ((opExec == OP_BR) && ((NZP & psr) != 3'b000));

    assign fwdAlu1 = execIsAlu && (IR[8:6] == IR_Exec[11:9]);
    assign fwdAlu2 = execIsAlu2 && !IR[5] && (IR[2:0] == IR_Exec[11:9]);
    assign fwdMem1 = execIsLoad && (IR[8:6] == IR_Exec[11:9]);

`ifdef LC3_CTRL_BYPASS_EN
    assign dataStall = 1'b0;
`else
    logic hazardStall_q, hazardStall_d;

    // Stall once per hazard; the second cycle lets the producer reach writeback.
    assign hazardStall_d = (fwdAlu1 || fwdAlu2 || fwdMem1) && !hazardStall_q;
    assign dataStall     = hazardStall_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hazardStall_q <= 1'b0;
        end else begin
            hazardStall_q <= hazardStall_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        memServed_d = memServed_q;
        loadDone_d  = loadDone_q;
        startCnt_d  = (startCnt_q == 2'd3) ? 2'd3 : startCnt_q + 2'd1;
        if (enable_execute) begin
            memServed_d = 1'b0;
            loadDone_d  = 1'b0;
        end
        case (state_q)
            MEM_IDLE: begin
                if (!memServed_q) begin
                    if ((opExec == OP_LD) || (opExec == OP_LDR)) begin
                        state_d = MEM_READ;
                    end else if ((opExec == OP_ST) || (opExec == OP_STR)) begin
                        state_d = MEM_WRITE;
                    end else if ((opExec == OP_LDI) || (opExec == OP_STI)) begin
                        state_d = MEM_INDIRECT;
                    end
                end
            end
            MEM_INDIRECT: begin
                if (complete_data) begin
                    state_d = (opExec == OP_LDI) ? MEM_READ : MEM_WRITE;
                end
            end
            MEM_READ: begin
                if (complete_data) begin
                    state_d     = MEM_IDLE;
                    memServed_d = 1'b1;
                    loadDone_d  = 1'b1;
                end
            end
            default: begin
                if (complete_data) begin
                    state_d     = MEM_IDLE;
                    memServed_d = 1'b1;
                    loadDone_d  = 1'b0;
                end
            end
        endcase
    end

    // Stall priority: memory access, then control flow, then instruction memory; data hazards add on top.
    always_comb begin
        enable_updatePC  = 1'b1;
        enable_fetch     = 1'b1;
        enable_decode    = (startCnt_q >= 2'd1);
        enable_execute   = (startCnt_q >= 2'd2);
        enable_writeback = (startCnt_q == 2'd3) || (memServed_q && loadDone_q);
        br_taken         = branchTaken;
`ifdef LC3_CTRL_BYPASS_EN
        bypass_alu_1     = fwdAlu1;
        bypass_alu_2     = fwdAlu2;
        bypass_mem_1     = fwdMem1;
`else
        bypass_alu_1     = 1'b0;
        bypass_alu_2     = 1'b0;
        bypass_mem_1     = 1'b0;
`endif
        if (state_q != MEM_IDLE) begin
            enable_updatePC  = 1'b0;
            enable_fetch     = 1'b0;
            enable_decode    = 1'b0;
            enable_execute   = 1'b0;
            enable_writeback = 1'b0;
        end else begin
            if (ctrlExec || ctrlDec) begin
                enable_updatePC = branchTaken;
                enable_fetch    = 1'b0;
            end else if (!complete_instr) begin
                enable_updatePC = 1'b0;
                enable_fetch    = 1'b0;
            end
            if (dataStall) begin
                enable_updatePC = 1'b0;
                enable_fetch    = 1'b0;
                enable_decode   = 1'b0;
            end
        end
        if (!reset) begin
            enable_updatePC  = 1'b1;
            enable_fetch     = 1'b1;
            enable_decode    = 1'b0;
            enable_execute   = 1'b0;
            enable_writeback = 1'b0;
            br_taken         = 1'b0;
            bypass_alu_1     = 1'b0;
            bypass_alu_2     = 1'b0;
            bypass_mem_1     = 1'b0;
        end
    end

    assign mem_state = state_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= MEM_IDLE;
            memServed_q <= 1'b0;
            loadDone_q  <= 1'b0;
            startCnt_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            memServed_q <= memServed_d;
            loadDone_q  <= loadDone_d;
            startCnt_q  <= startCnt_d;
        end
    end

endmodule

// File: tb/tb_lc3_pipeline_ctrl.sv
// Directed scoreboard bench for lc3_pipeline_ctrl; expectations follow LC3_CTRL_BYPASS_EN when it is defined.
module tb_lc3_pipeline_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        complete_instr, complete_data;
    logic [15:0] IR, IR_Exec, IMem_dout;
    logic [2:0]  NZP, psr;
    logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
    logic        br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1;
    logic [1:0]  mem_state;

    logic [10:0] expQ[$];
    int          total = 0;
    int          bad = 0;

`ifdef LC3_CTRL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clock = ~clock;

    lc3_pipeline_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .IR               (IR),
        .IR_Exec          (IR_Exec),
        .IMem_dout        (IMem_dout),
        .NZP              (NZP),
        .psr              (psr),
        .enable_updatePC  (enable_updatePC),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .br_taken         (br_taken),
        .bypass_alu_1     (bypass_alu_1),
        .bypass_alu_2     (bypass_alu_2),
        .bypass_mem_1     (bypass_mem_1),
        .mem_state        (mem_state)
    );

    // Packs {updatePC, fetch, decode, execute, writeback, br_taken, alu1, alu2, mem1, mem_state}.
    function automatic logic [10:0] mk(input logic upc, input logic f, input logic d, input logic e,
                                       input logic w, input logic br, input logic b1, input logic b2,
                                       input logic bm, input logic [1:0] ms);
        return {upc, f, d, e, w, br, b1, b2, bm, ms};
    endfunction

    task automatic checkOutput(input string tag);
        logic [10:0] obs;
        logic [10:0] expv;
        expv = expQ.pop_front();
        obs  = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
                br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, mem_state};
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic ci, input logic cd,
                                 input logic [15:0] ir, input logic [15:0] irExec,
                                 input logic [2:0] nzp, input logic [2:0] ps,
                                 input logic [10:0] expv, input string tag);
        reset          = rst;
        complete_instr = ci;
        complete_data  = cd;
        IR             = ir;
        IR_Exec        = irExec;
        NZP            = nzp;
        psr            = ps;
        expQ.push_back(expv);
        @(negedge clock);
        checkOutput(tag);
        @(posedge clock);
        #1;
    endtask

    initial begin
        IMem_dout = 16'h0000;
        // Reset forces outputs even with hazard / jump instructions present.
        applyStimulus(0, 1, 0, 16'h1441, 16'h1262, 3'b000, 3'b010, mk(1,1,0,0,0,0,0,0,0,3), "rst_hazard");
        applyStimulus(0, 1, 0, 16'h0000, 16'hC1C0, 3'b000, 3'b010, mk(1,1,0,0,0,0,0,0,0,3), "rst_jmp");
        // Startup ramp with a NOP stream.
        applyStimulus(1, 1, 0, 16'h0000, 16'h0000, 3'b000, 3'b010, mk(1,1,0,0,0,0,0,0,0,3), "start_c0");
        applyStimulus(1, 1, 0, 16'h0000, 16'h0000, 3'b000, 3'b010, mk(1,1,1,0,0,0,0,0,0,3), "start_c1");
        applyStimulus(1, 1, 0, 16'h0000, 16'h0000, 3'b000, 3'b010, mk(1,1,1,1,0,0,0,0,0,3), "start_c2");
        applyStimulus(1, 1, 0, 16'h0000, 16'h0000, 3'b000, 3'b010, mk(1,1,1,1,1,0,0,0,0,3), "start_c3");
        applyStimulus(1, 1, 0, 16'h0000, 16'h0000, 3'b000, 3'b010, mk(1,1,1,1,1,0,0,0,0,3), "start_sat");
        // Branch / jump resolution and stall priority.
        applyStimulus(1, 1, 0, 16'h0000, 16'h0405, 3'b010, 3'b010, mk(1,0,1,1,1,1,0,0,0,3), "brz_taken");
        applyStimulus(1, 1, 0, 16'h0000, 16'h0405, 3'b010, 3'b100, mk(0,0,1,1,1,0,0,0,0,3), "brz_not_taken");
        applyStimulus(1, 0, 0, 16'h0000, 16'h0405, 3'b010, 3'b010, mk(1,0,1,1,1,1,0,0,0,3), "br_over_imem");
        applyStimulus(1, 1, 0, 16'hC1C0, 16'h0000, 3'b000, 3'b010, mk(0,0,1,1,1,0,0,0,0,3), "jmp_in_decode");
        applyStimulus(1, 1, 0, 16'h0000, 16'hC1C0, 3'b000, 3'b010, mk(1,0,1,1,1,1,0,0,0,3), "jmp_in_exec");
        applyStimulus(1, 0, 0, 16'h0000, 16'h0000, 3'b000, 3'b010, mk(0,0,1,1,1,0,0,0,0,3), "imem_stall");
        // ALU forwarding, or a single stall cycle when forwarding is absent.
        applyStimulus(1, 1, 0, 16'h1441, 16'h1262, 3'b000, 3'b010,
                      BYP ? mk(1,1,1,1,1,0,1,1,0,3) : mk(0,0,0,1,1,0,0,0,0,3), "alu_hazard_c1");
        applyStimulus(1, 1, 0, 16'h1441, 16'h1262, 3'b000, 3'b010,
                      BYP ? mk(1,1,1,1,1,0,1,1,0,3) : mk(1,1,1,1,1,0,0,0,0,3), "alu_hazard_c2");
        applyStimulus(1, 1, 0, 16'h0000, 16'h1262, 3'b000, 3'b010, mk(1,1,1,1,1,0,0,0,0,3), "alu_no_hazard");
        // LDI walk: IDLE -> INDIRECT -> READ -> IDLE with completions on cycles 3 and 6.
        applyStimulus(1, 1, 0, 16'h0000, 16'hA200, 3'b000, 3'b010, mk(1,1,1,1,1,0,0,0,0,3), "ldi_c1_idle");
        applyStimulus(1, 1, 0, 16'h0000, 16'hA200, 3'b000, 3'b010, mk(0,0,0,0,0,0,0,0,0,2), "ldi_c2_ind");
        applyStimulus(1, 1, 1, 16'h0000, 16'hA200, 3'b000, 3'b010, mk(0,0,0,0,0,0,0,0,0,2), "ldi_c3_ind_done");
        applyStimulus(1, 1, 0, 16'h0000, 16'hA200, 3'b000, 3'b010, mk(0,0,0,0,0,0,0,0,0,0), "ldi_c4_read");
        applyStimulus(1, 1, 0, 16'h0000, 16'hA200, 3'b000, 3'b010, mk(0,0,0,0,0,0,0,0,0,0), "ldi_c5_read");
        applyStimulus(1, 1, 1, 16'h0000, 16'hA200, 3'b000, 3'b010, mk(0,0,0,0,0,0,0,0,0,0), "ldi_c6_read_done");
        applyStimulus(1, 1, 0, 16'h0000, 16'hA200, 3'b000, 3'b010, mk(1,1,1,1,1,0,0,0,0,3), "ldi_c7_served");
        applyStimulus(1, 1, 0, 16'h0000, 16'h0000, 3'b000, 3'b010, mk(1,1,1,1,1,0,0,0,0,3), "ldi_c8_idle");
        // LD with a dependent consumer, then reset while the read is in flight.
        applyStimulus(1, 1, 0, 16'h1441, 16'h2200, 3'b000, 3'b010,
                      BYP ? mk(1,1,1,1,1,0,0,0,1,3) : mk(0,0,0,1,1,0,0,0,0,3), "ld_hazard_idle");
        applyStimulus(1, 1, 0, 16'h1441, 16'h2200, 3'b000, 3'b010,
                      BYP ? mk(0,0,0,0,0,0,0,0,1,0) : mk(0,0,0,0,0,0,0,0,0,0), "ld_read");
        applyStimulus(0, 1, 1, 16'h1441, 16'h2200, 3'b000, 3'b010, mk(1,1,0,0,0,0,0,0,0,3), "rst_mid_read");
        applyStimulus(1, 1, 0, 16'h0000, 16'h0000, 3'b000, 3'b010, mk(1,1,0,0,0,0,0,0,0,3), "after_abort");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
